// File: rtl/bridge_utils_pkg.sv
// Shared AXI-to-APB bridge definitions: bus widths, APB completer FSM states
// and wait-counter width.
package bridge_utils;

    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned CPL_CNT_W  = 4;

    typedef enum logic [0:0] {
        C_IDLE   = 1'b0,
        C_ACCESS = 1'b1
    } apb_cpl_state_t;

endpackage

// File: rtl/apb_cpl_regfile.sv
// Word storage for the APB completer: async clear, one byte-masked write port,
// one combinational read port.
module apb_cpl_regfile #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       we_i,
    input  logic [$clog2(DEPTH)-1:0]   widx_i,
    input  logic [DATA_WIDTH-1:0]      wdata_i,
    input  logic [DATA_WIDTH/8-1:0]    wmask_i,
    input  logic [$clog2(DEPTH)-1:0]   ridx_i,
    output logic [DATA_WIDTH-1:0]      rdata_o
);

    localparam int unsigned NB = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we_i) begin
            for (int k = 0; k < NB; k++) begin
                if (wmask_i[k]) begin
                    r_mem[widx_i][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

    assign rdata_o = r_mem[ridx_i];

endmodule

// File: rtl/apb_completer_mem.sv
// APB completer backed by a small register memory with programmable wait states.
// Optional APB_COMPLETER_PSTRB_EN: honour pstrb_i byte lanes on writes.
module apb_completer_mem #(
    parameter int unsigned            ADDR_WIDTH  = bridge_utils::ADDR_WIDTH,
    parameter int unsigned            DATA_WIDTH  = bridge_utils::DATA_WIDTH,
    parameter int unsigned            DEPTH       = 16,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR   = '0,
    parameter int unsigned            WAIT_CYCLES = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      psel_i,
    input  logic                      penable_i,
    input  logic [ADDR_WIDTH-1:0]     paddr_i,
    input  logic                      pwrite_i,
    input  logic [DATA_WIDTH-1:0]     pwdata_i,
    input  logic [DATA_WIDTH/8-1:0]   pstrb_i,
    output logic                      pready_o,
    output logic [DATA_WIDTH-1:0]     prdata_o,
    output logic                      pslverr_o
);

    import bridge_utils::*;

    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    apb_cpl_state_t          r_state;
    apb_cpl_state_t          w_state_nxt;
    logic [CPL_CNT_W-1:0]    r_cnt;
    logic [CPL_CNT_W-1:0]    w_cnt_nxt;
    logic [IDX_W-1:0]        r_idx;
    logic                    r_err;
    logic                    r_write;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [STRB_W-1:0]       w_mask;
    logic [DATA_WIDTH-1:0]   w_rdata;
    logic [ADDR_WIDTH:0]     w_offset;
    logic                    w_dec_err;
    logic                    w_capture;
    logic                    w_we;
    logic                    w_done;

    // Decode in ADDR_WIDTH+1 bits so an address below the base cannot wrap into range.
    assign w_offset  = {1'b0, paddr_i} - {1'b0, BASE_ADDR};
    assign w_dec_err = (paddr_i < BASE_ADDR)
                    || (w_offset[1:0] != 2'b00)
                    || ((w_offset >> 2) >= (ADDR_WIDTH+1)'(DEPTH));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        w_we        = 1'b0;
        case (r_state)
            C_IDLE: begin
                if (psel_i && !penable_i) begin
                    w_capture   = 1'b1;
                    w_cnt_nxt   = CPL_CNT_W'(WAIT_CYCLES);
                    w_state_nxt = C_ACCESS;
                end
            end
            C_ACCESS: begin
                if (!psel_i) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = C_IDLE;
                end else if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CPL_CNT_W'(1);
                end else begin
                    w_we        = r_write && !r_err;
                    w_state_nxt = C_IDLE;
                end
            end
            default: begin
                w_state_nxt = C_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= C_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Transfer attributes latched in SETUP; outputs depend only on these.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_err   <= 1'b0;
            r_write <= 1'b0;
            r_wdata <= '0;
        end else if (w_capture) begin
            r_idx   <= w_offset[IDX_W+1:2];
            r_err   <= w_dec_err;
            r_write <= pwrite_i;
            r_wdata <= pwdata_i;
        end
    end

`ifdef APB_COMPLETER_PSTRB_EN
    logic [STRB_W-1:0] r_strb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_strb <= '0;
        end else if (w_capture) begin
            r_strb <= pstrb_i;
        end
    end

    assign w_mask = r_strb;
`else
    logic w_unused_strb;

    assign w_unused_strb = ^pstrb_i;
    assign w_mask        = '1;
`endif

    apb_cpl_regfile #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (w_we),
        .widx_i  (r_idx),
        .wdata_i (r_wdata),
        .wmask_i (w_mask),
        .ridx_i  (r_idx),
        .rdata_o (w_rdata)
    );

    assign w_done    = (r_state == C_ACCESS) && (r_cnt == '0);
    assign pready_o  = w_done;
    assign pslverr_o = w_done && r_err;
    assign prdata_o  = (w_done && !r_write && !r_err) ? w_rdata : '0;

endmodule

// File: tb/tb_apb_completer_mem.sv
// Scoreboard bench for apb_completer_mem: directed scenarios plus random traffic
// checked against an array-based memory model.
module tb_apb_completer_mem;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned WAIT  = 1;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        psel    = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite  = 1'b0;
    logic [31:0] paddr   = '0;
    logic [31:0] pwdata  = '0;
    logic [3:0]  pstrb   = '0;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    always #5 clk = ~clk;

    apb_completer_mem #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .DEPTH       (DEPTH),
        .BASE_ADDR   (BASE),
        .WAIT_CYCLES (WAIT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .psel_i    (psel),
        .penable_i (penable),
        .paddr_i   (paddr),
        .pwrite_i  (pwrite),
        .pwdata_i  (pwdata),
        .pstrb_i   (pstrb),
        .pready_o  (pready),
        .prdata_o  (prdata),
        .pslverr_o (pslverr)
    );

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        string       name;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] model [DEPTH];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic bit addr_bad(input logic [31:0] a);
        longint off;
        off = longint'(a) - longint'(BASE);
        return (off < 0) || (off % 4 != 0) || (off / 4 >= longint'(DEPTH));
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d,
                                        input logic [3:0] s);
        logic [3:0] m;
        m = s;
`ifndef APB_COMPLETER_PSTRB_EN
        m = 4'hF;
`endif
        if (!addr_bad(a)) begin
            for (int k = 0; k < 4; k++) begin
                if (m[k]) model[(a - BASE) / 4][8*k +: 8] = d[8*k +: 8];
            end
        end
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endfunction

    // Full transfer; entered and left at posedge+1.
    task automatic xfer(input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input bit use_exp, input logic [31:0] exp_d,
                        input string nm);
        exp_t e;
        int   n;
        e.err  = addr_bad(a);
        e.name = nm;
        if (w || e.err) e.rdata = '0;
        else            e.rdata = use_exp ? exp_d : model[(a - BASE) / 4];
        if (w) model_write(a, d, s);
        q.push_back(e);
        psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d; pstrb = s;
        @(posedge clk); #1;
        penable = 1'b1;
        n = 0;
        while (!pready && n < 16) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, " latency"}, 32'(n), WAIT);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic abort_wr(input logic [31:0] a, input logic [31:0] d);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d; pstrb = 4'hF;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        chk("abort_no_pready", 32'(pready), 32'(0));
        @(posedge clk); #1;
        pwrite = 1'b0;
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(posedge clk); #1;
        end
    endtask

    // Monitor: every completion pops one expectation; otherwise outputs must be quiet.
    always @(negedge clk) begin
        if (rst_n) begin
            if (pready) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_pready: got pready=1 expected no transfer pending");
                end else begin
                    mon_e = q.pop_front();
                    chk({mon_e.name, " pslverr"}, 32'(pslverr), 32'(mon_e.err));
                    chk({mon_e.name, " prdata"}, prdata, mon_e.rdata);
                end
            end else begin
                chk("quiet_prdata", prdata, '0);
                chk("quiet_pslverr", 32'(pslverr), '0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] strb_exp;
        bit          w;

        model_clear();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_pready", 32'(pready), '0);
        chk("reset_prdata", prdata, '0);
        chk("reset_pslverr", 32'(pslverr), '0);
        rst_n = 1'b1;
        idle(2);

        xfer(1, 32'h04, 32'hDEADBEEF, 4'hF, 0, '0, "wr04");
        idle(1);
        xfer(0, 32'h04, '0, 4'h0, 1, 32'hDEADBEEF, "rd04");
        idle(1);

        xfer(0, 32'h40, '0, 4'h0, 0, '0, "rd40_oob");
        xfer(0, 32'h06, '0, 4'h0, 0, '0, "rd06_misaligned");
        xfer(1, 32'h44, 32'h12345678, 4'hF, 0, '0, "wr44_oob");
        xfer(0, 32'h00, '0, 4'h0, 1, 32'h0, "rd00_after_err");
        idle(1);

        xfer(1, 32'h00, 32'h11, 4'hF, 0, '0, "b2b_wr00");
        xfer(1, 32'h08, 32'h22, 4'hF, 0, '0, "b2b_wr08");
        xfer(0, 32'h00, '0, 4'h0, 1, 32'h11, "b2b_rd00");
        xfer(0, 32'h08, '0, 4'h0, 1, 32'h22, "b2b_rd08");
        idle(1);

`ifdef APB_COMPLETER_PSTRB_EN
        strb_exp = 32'hAA22CC44;
`else
        strb_exp = 32'h11223344;
`endif
        xfer(1, 32'h0C, 32'hAABBCCDD, 4'hF, 0, '0, "strb_init");
        xfer(1, 32'h0C, 32'h11223344, 4'b0101, 0, '0, "strb_wr");
        xfer(0, 32'h0C, '0, 4'h0, 1, strb_exp, "strb_rd");
        idle(1);

        xfer(1, 32'h10, 32'h5A5A1234, 4'hF, 0, '0, "pre_abort_wr10");
        abort_wr(32'h10, 32'hFFFFFFFF);
        xfer(0, 32'h10, '0, 4'h0, 1, 32'h5A5A1234, "post_abort_rd10");
        idle(1);

        // Reset asserted while the write to 0x14 is completing.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h14; pwdata = 32'hCAFEF00D; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_pready_before", 32'(pready), 32'(1));
        rst_n = 1'b0;
        #1;
        chk("rst_mid_pready", 32'(pready), '0);
        chk("rst_mid_prdata", prdata, '0);
        chk("rst_mid_pslverr", 32'(pslverr), '0);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        model_clear();
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);
        xfer(0, 32'h14, '0, 4'h0, 1, 32'h0, "rd14_after_rst");
        xfer(0, 32'h04, '0, 4'h0, 1, 32'h0, "rd04_after_rst");

        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 7))
                0, 1, 2, 3, 4: a = 32'($urandom_range(0, DEPTH - 1)) * 4;
                5:             a = 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
                6:             a = 32'(DEPTH * 4) + 32'($urandom_range(0, 15)) * 4;
                default:       a = $urandom;
            endcase
            a = a + BASE;
            d = $urandom;
            w = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 15) == 0) begin
                abort_wr(a, d);
            end else begin
                xfer(w, a, d, 4'($urandom), 0, '0, w ? "rand_wr" : "rand_rd");
            end
            idle($urandom_range(0, 2));
        end

        idle(3);
        chk("queue_drained", 32'(q.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
